mult_prod_accumulator: RTL and testbench
========================================

// Module: mult_prod_accumulator
// PURPOSE
//   Downstream stage of the 8x8 approximate multiplier. It consumes the 16-bit products
//   as a valid/ready stream and sums each vector of products into one dot-product result.
//   Each result is held on a valid/ready output port for the reduction or writeback stage.
//   Used to measure how approximation error accumulates over MAC-style workloads.
// PARAMETERS
//   PROD_W   16   width of incoming product (matches multiplier R output)
//   ACC_W    24   accumulator/result width; must be >= PROD_W
//   MAX_LEN  256  max beats per vector; a vector auto-closes at this count
// PORTS
//   clk        in   1                      rising-edge clock
//   rst        in   1                      synchronous reset, active-high
//   in_valid   in   1                      product beat valid
//   in_ready   out  1                      block can accept a beat
//   in_prod    in   PROD_W                 unsigned product from multiplier
//   in_last    in   1                      beat is final of current vector
//   out_valid  out  1                      result valid
//   out_ready  in   1                      consumer accepts result
//   out_sum    out  ACC_W                  accumulated vector sum
//   out_count  out  $clog2(MAX_LEN+1)      number of beats in result
//   out_ovf    out  1                      sum exceeded 2^ACC_W-1 during vector
// BEHAVIOUR
//   - Reset (sync, rst=1 at clk edge): state=IDLE; out_valid=0, out_sum=0, out_count=0, out_ovf=0;
//     the accumulator and the count are cleared. Reset mid-vector discards the partial sum.
//   - FSM states:
//     IDLE: no vector open. An accepted beat goes to ACCUM, or to HOLD if it closes the vector.
//     ACCUM: vector open. A beat that closes the vector goes to HOLD.
//     HOLD: result presented on the output port.
//   - Handshake: a beat is accepted when in_valid && in_ready. in_ready = (state!=HOLD) || out_ready.
//     A result transfers when out_valid && out_ready.
//   - First beat of a vector: acc <= in_prod, cnt <= 1, ovf <= 0.
//     Later beats: acc <= acc + in_prod, computed at ACC_W+1 bits; cnt <= cnt+1.
//   - A vector closes on an accepted beat with in_last=1, or when that beat makes cnt==MAX_LEN.
//   - Latency: out_valid rises on the cycle after the closing beat is accepted.
//     out_sum, out_count and out_ovf are registered and stable while out_valid && !out_ready.
//   - HOLD with out_ready=1 and no accepted beat: out_valid falls next cycle, next state IDLE.
//   - HOLD with out_ready=1 and an accepted beat: the result transfers and the beat starts a new
//     vector in the same cycle. If that beat also closes, the block stays in HOLD with the new result.
//     There are no bubbles in either case.
//   - Zero-length vectors cannot occur; every vector holds at least one beat.
//   - Inputs are ignored while in_ready=0. No beat is ever dropped or double-counted.
// CONFIGURATION
//   Macro ACC_SATURATE_EN:
//   - Defined: on overflow, acc is clamped to 2^ACC_W-1 and out_ovf=1. Later beats keep it clamped.
//   - Undefined: acc wraps modulo 2^ACC_W. out_ovf is still set sticky per vector on any carry-out.
// STRUCTURE
//   - Shared package holds:
//     - FSM state typedef {IDLE, ACCUM, HOLD}
//     - default PROD_W/ACC_W/MAX_LEN constants
//     - count-width function clog2(MAX_LEN+1)
//   - One natural sub-module: acc_add_sat. It is combinational and takes acc, prod and the
//     first-beat flag; it returns next acc and the overflow flag. The ACC_SATURATE_EN branch lives here.
//   - FSM, counter and output registers stay in the top module.
// TESTING
//   1. Beats 100, 200, 300 (last on 300), out_ready=1
//      -> one cycle later out_valid=1, out_sum=600, out_count=3, out_ovf=0.
//   2. ACC_W=17, beats 0xFFFF x3, last on third
//      -> with ACC_SATURATE_EN: out_sum=0x1FFFF, out_ovf=1.
//      -> without it: out_sum=0x0FFFD, out_ovf=1.
//   3. MAX_LEN=4, six beats of 1, never last, out_ready=1
//      -> result sum=4, count=4. Next vector starts with beat 5; in_last on beat 6 gives sum=2, count=2.
//   4. Hold out_ready=0 for 5 cycles after a result
//      -> out_valid, out_sum and out_count stay stable, in_ready=0.
//      -> Raise out_ready with a beat 7, last=1: the result transfers, and next cycle out_sum=7, count=1.
//   5. Assert rst after 2 of 3 beats (10, 20), then send 5 with last=1
//      -> out_sum=5, out_count=1. Outputs read 0 during reset.
//   6. Random valid/ready toggling, 1000 vectors vs. a reference model -> all sums and counts match.

Source files
------------

// File: rtl/mult_prod_accumulator_pkg.sv
// Shared types and defaults for the product accumulator stage.
// Build option ACC_SATURATE_EN selects clamping instead of wrapping.
package mult_prod_accumulator_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } acc_state_t;

    localparam int PROD_W_DEF  = 16;
    localparam int ACC_W_DEF   = 24;
    localparam int MAX_LEN_DEF = 256;

    // Width that can represent every beat count from 0 to max_len inclusive.
    function automatic int cnt_w(input int max_len);
        return $clog2(max_len + 1);
    endfunction

endpackage

// File: rtl/mult_prod_accumulator_add_sat.sv
// Combinational accumulate step: next sum and carry-out for one beat.
// ACC_SATURATE_EN clamps to all-ones on carry-out; otherwise wraps.
module acc_add_sat
    import mult_prod_accumulator_pkg::*;
#(
    parameter int PROD_W = PROD_W_DEF,
    parameter int ACC_W  = ACC_W_DEF
) (
    input  logic [ACC_W-1:0]  acc,
    input  logic [PROD_W-1:0] prod,
    input  logic              first,
    output logic [ACC_W-1:0]  sum,
    output logic              ovf
);

    logic [ACC_W:0] wide;

    always_comb begin
        // A first beat restarts the vector, so the old acc is ignored.
        if (first) begin
            wide = (ACC_W+1)'(prod);
        end else begin
            wide = {1'b0, acc} + (ACC_W+1)'(prod);
        end
        ovf = wide[ACC_W];
`ifdef ACC_SATURATE_EN
        sum = ovf ? '1 : wide[ACC_W-1:0];
`else
        sum = wide[ACC_W-1:0];
`endif
    end

endmodule

// File: rtl/mult_prod_accumulator.sv
// Sums streamed multiplier products into one result per vector.
// Overflow policy chosen by ACC_SATURATE_EN (see acc_add_sat).
module mult_prod_accumulator
    import mult_prod_accumulator_pkg::*;
#(
    parameter int PROD_W  = PROD_W_DEF,
    parameter int ACC_W   = ACC_W_DEF,
    parameter int MAX_LEN = MAX_LEN_DEF
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [PROD_W-1:0]           in_prod,
    input  logic                        in_last,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [ACC_W-1:0]            out_sum,
    output logic [cnt_w(MAX_LEN)-1:0]   out_count,
    output logic                        out_ovf
);

    localparam int CW = cnt_w(MAX_LEN);

    acc_state_t     state;
    acc_state_t     state_nxt;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] acc_nxt;
    logic [CW-1:0]  cnt;
    logic [CW-1:0]  cnt_nxt;
    logic           ovf;
    logic           ovf_nxt;
    logic           add_ovf;
    logic           first;
    logic           accept;
    logic           close;

    // HOLD only blocks input when the held result cannot leave this cycle.
    assign in_ready  = (state != HOLD) || out_ready;
    assign out_valid = (state == HOLD);
    assign accept    = in_valid && in_ready;
    assign first     = (state != ACCUM);

    acc_add_sat #(
        .PROD_W (PROD_W),
        .ACC_W  (ACC_W)
    ) u_add (
        .acc    (acc),
        .prod   (in_prod),
        .first  (first),
        .sum    (acc_nxt),
        .ovf    (add_ovf)
    );

    always_comb begin
        cnt_nxt = first ? CW'(1) : cnt + CW'(1);
        ovf_nxt = add_ovf | (ovf & ~first);
        close   = in_last || (cnt_nxt == CW'(MAX_LEN));
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, ACCUM: begin
                if (accept) begin
                    state_nxt = close ? HOLD : ACCUM;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    if (accept) begin
                        state_nxt = close ? HOLD : ACCUM;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            acc       <= '0;
            cnt       <= '0;
            ovf       <= 1'b0;
            out_sum   <= '0;
            out_count <= '0;
            out_ovf   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                acc <= acc_nxt;
                cnt <= cnt_nxt;
                ovf <= ovf_nxt;
                if (close) begin
                    out_sum   <= acc_nxt;
                    out_count <= cnt_nxt;
                    out_ovf   <= ovf_nxt;
                end
            end
        end
    end

endmodule

// File: tb/tb_mult_prod_accumulator.sv
// Directed and randomized checks for mult_prod_accumulator.
// Three instances: defaults, ACC_W=17, MAX_LEN=4.
module tb_mult_prod_accumulator;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // default instance
    logic        d_in_valid = 0, d_in_ready, d_in_last = 0;
    logic [15:0] d_in_prod = 0;
    logic        d_out_valid, d_out_ready = 0, d_out_ovf;
    logic [23:0] d_out_sum;
    logic [8:0]  d_out_count;

    // ACC_W = 17 instance
    logic        a_in_valid = 0, a_in_ready, a_in_last = 0;
    logic [15:0] a_in_prod = 0;
    logic        a_out_valid, a_out_ready = 1, a_out_ovf;
    logic [16:0] a_out_sum;
    logic [8:0]  a_out_count;

    // MAX_LEN = 4 instance
    logic        m_in_valid = 0, m_in_ready, m_in_last = 0;
    logic [15:0] m_in_prod = 0;
    logic        m_out_valid, m_out_ready = 1, m_out_ovf;
    logic [23:0] m_out_sum;
    logic [2:0]  m_out_count;

    mult_prod_accumulator u_dut (
        .clk(clk), .rst(rst),
        .in_valid(d_in_valid), .in_ready(d_in_ready),
        .in_prod(d_in_prod), .in_last(d_in_last),
        .out_valid(d_out_valid), .out_ready(d_out_ready),
        .out_sum(d_out_sum), .out_count(d_out_count), .out_ovf(d_out_ovf)
    );

    mult_prod_accumulator #(.ACC_W(17)) u_w17 (
        .clk(clk), .rst(rst),
        .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_prod(a_in_prod), .in_last(a_in_last),
        .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_sum(a_out_sum), .out_count(a_out_count), .out_ovf(a_out_ovf)
    );

    mult_prod_accumulator #(.MAX_LEN(4)) u_m4 (
        .clk(clk), .rst(rst),
        .in_valid(m_in_valid), .in_ready(m_in_ready),
        .in_prod(m_in_prod), .in_last(m_in_last),
        .out_valid(m_out_valid), .out_ready(m_out_ready),
        .out_sum(m_out_sum), .out_count(m_out_count), .out_ovf(m_out_ovf)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one beat on the default instance; returns at posedge+1 after acceptance.
    task automatic beat(input logic [15:0] p, input logic last);
        bit done = 0;
        d_in_valid = 1;
        d_in_prod  = p;
        d_in_last  = last;
        for (int t = 0; t < 50 && !done; t++) begin
            @(negedge clk);
            if (d_in_ready) done = 1;
            @(posedge clk); #1;
        end
        check("beat_accept", {31'd0, done}, 32'd1);
        d_in_valid = 0;
        d_in_last  = 0;
    endtask

    logic [23:0] q_sum[$];
    logic [8:0]  q_cnt[$];
    int          got;
    logic [31:0] exp_a_sum;

    initial begin
        // reset state on all instances
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid", {31'd0, d_out_valid}, 0);
        check("rst_sum", {8'd0, d_out_sum}, 0);
        check("rst_count", {23'd0, d_out_count}, 0);
        check("rst_ovf", {31'd0, d_out_ovf}, 0);
        check("rst_ready", {31'd0, d_in_ready}, 1);
        check("rst_a_valid", {31'd0, a_out_valid}, 0);
        check("rst_m_valid", {31'd0, m_out_valid}, 0);
        @(posedge clk); #1;
        rst = 0;

        // basic three-beat vector
        d_out_ready = 1;
        beat(16'd100, 0);
        beat(16'd200, 0);
        @(negedge clk);
        check("t1_not_yet", {31'd0, d_out_valid}, 0);
        @(posedge clk); #1;
        beat(16'd300, 1);
        @(negedge clk);
        check("t1_valid", {31'd0, d_out_valid}, 1);
        check("t1_sum", {8'd0, d_out_sum}, 600);
        check("t1_count", {23'd0, d_out_count}, 3);
        check("t1_ovf", {31'd0, d_out_ovf}, 0);
        @(posedge clk); #1;
        @(negedge clk);
        check("t1_drop", {31'd0, d_out_valid}, 0);
        @(posedge clk); #1;

        // overflow at ACC_W=17
        a_in_valid = 1;
        a_in_prod  = 16'hFFFF;
        a_in_last  = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        a_in_last = 1;
        @(posedge clk); #1;
        a_in_valid = 0;
        a_in_last  = 0;
        @(negedge clk);
`ifdef ACC_SATURATE_EN
        exp_a_sum = 32'h1FFFF;
`else
        exp_a_sum = 32'h0FFFD;
`endif
        check("t2_valid", {31'd0, a_out_valid}, 1);
        check("t2_sum", {15'd0, a_out_sum}, exp_a_sum);
        check("t2_ovf", {31'd0, a_out_ovf}, 1);
        check("t2_count", {23'd0, a_out_count}, 3);
        @(posedge clk); #1;

        // auto-close at MAX_LEN=4, next vector starts without a bubble
        for (int i = 0; i < 6; i++) begin
            m_in_valid = 1;
            m_in_prod  = 16'd1;
            m_in_last  = (i == 5);
            if (i == 4) begin
                @(negedge clk);
                check("t3_valid", {31'd0, m_out_valid}, 1);
                check("t3_sum", {8'd0, m_out_sum}, 4);
                check("t3_count", {29'd0, m_out_count}, 4);
                check("t3_ready", {31'd0, m_in_ready}, 1);
            end
            @(posedge clk); #1;
        end
        m_in_valid = 0;
        m_in_last  = 0;
        @(negedge clk);
        check("t3b_valid", {31'd0, m_out_valid}, 1);
        check("t3b_sum", {8'd0, m_out_sum}, 2);
        check("t3b_count", {29'd0, m_out_count}, 2);
        @(posedge clk); #1;

        // backpressure: result held, offered beat ignored
        d_out_ready = 0;
        beat(16'd9, 1);
        d_in_valid = 1;
        d_in_prod  = 16'd7;
        d_in_last  = 1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t4_valid", {31'd0, d_out_valid}, 1);
            check("t4_sum", {8'd0, d_out_sum}, 9);
            check("t4_count", {23'd0, d_out_count}, 1);
            check("t4_ready", {31'd0, d_in_ready}, 0);
            @(posedge clk); #1;
        end
        d_out_ready = 1;
        @(negedge clk);
        check("t4_xfer_ready", {31'd0, d_in_ready}, 1);
        check("t4_xfer_sum", {8'd0, d_out_sum}, 9);
        @(posedge clk); #1;
        d_in_valid = 0;
        d_in_last  = 0;
        @(negedge clk);
        check("t4_new_valid", {31'd0, d_out_valid}, 1);
        check("t4_new_sum", {8'd0, d_out_sum}, 7);
        check("t4_new_count", {23'd0, d_out_count}, 1);
        @(posedge clk); #1;
        @(negedge clk);
        check("t4_idle", {31'd0, d_out_valid}, 0);
        @(posedge clk); #1;

        // reset mid-vector discards partial sum
        beat(16'd10, 0);
        beat(16'd20, 0);
        rst = 1;
        @(posedge clk); #1;
        @(negedge clk);
        check("t5_rst_valid", {31'd0, d_out_valid}, 0);
        check("t5_rst_sum", {8'd0, d_out_sum}, 0);
        check("t5_rst_count", {23'd0, d_out_count}, 0);
        @(posedge clk); #1;
        rst = 0;
        beat(16'd5, 1);
        @(negedge clk);
        check("t5_sum", {8'd0, d_out_sum}, 5);
        check("t5_count", {23'd0, d_out_count}, 1);
        @(posedge clk); #1;
        @(posedge clk); #1;

        // random valid/ready traffic against a reference model
        got = 0;
        fork
            begin : drv
                logic [15:0] bt[6];
                int len, cyc;
                logic [23:0] s;
                bit ok;
                cyc = 0;
                for (int v = 0; v < 1000 && cyc < 60000; v++) begin
                    len = $urandom_range(1, 6);
                    s = 0;
                    for (int b = 0; b < len; b++) begin
                        bt[b] = 16'($urandom_range(0, 65535));
                        s = s + 24'(bt[b]);
                    end
                    q_sum.push_back(s);
                    q_cnt.push_back(9'(len));
                    for (int b = 0; b < len; b++) begin
                        ok = 0;
                        while (!ok && cyc < 60000) begin
                            d_in_valid = ($urandom % 4) != 0;
                            d_in_prod  = bt[b];
                            d_in_last  = (b == len - 1);
                            @(negedge clk);
                            ok = d_in_valid && d_in_ready;
                            @(posedge clk); #1;
                            cyc++;
                        end
                    end
                end
                d_in_valid = 0;
                d_in_last  = 0;
            end
            begin : mon
                int cyc;
                cyc = 0;
                while (got < 1000 && cyc < 60000) begin
                    d_out_ready = ($urandom % 3) != 0;
                    @(negedge clk);
                    if (d_out_valid && d_out_ready) begin
                        if (q_sum.size() == 0) begin
                            check("rand_unexpected", 0, 1);
                        end else begin
                            check("rand_sum", {8'd0, d_out_sum}, {8'd0, q_sum.pop_front()});
                            check("rand_count", {23'd0, d_out_count}, {23'd0, q_cnt.pop_front()});
                        end
                        got++;
                    end
                    @(posedge clk); #1;
                    cyc++;
                end
                d_out_ready = 1;
            end
        join
        check("rand_results", got, 1000);
        check("rand_leftover", q_sum.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
